// File: rtl/fp_exp_align_pkg.sv
// Shared defaults and types for the FPU adder exponent-compare / mantissa-align front end.
package fp_exp_align_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 24;
  localparam int GRD_W_DEF = 3;

  // One aligned operand pair as it leaves the block (default widths).
  typedef struct packed {
    logic                               a_gr_b;
    logic [EXP_W_DEF-1:0]               e_big;
    logic [EXP_W_DEF-1:0]               diff;
    logic [MAN_W_DEF+GRD_W_DEF-1:0]     m_big;
    logic [MAN_W_DEF+GRD_W_DEF-1:0]     m_small;
  } fp_align_t;

  // Width of a mantissa once the guard bits are appended below its LSB.
  function automatic int align_w(input int man_w, input int grd_w);
    return man_w + grd_w;
  endfunction

endpackage

// File: rtl/fp_exp_align_if.sv
// Operand-in / aligned-result-out bundle with valid/ready on both sides.
// master: the environment (drives operands, consumes results); slave: the aligner.
interface fp_exp_align_if
  import fp_exp_align_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int GRD_W = GRD_W_DEF
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W-1:0]       ea;
  logic [EXP_W-1:0]       eb;
  logic [MAN_W-1:0]       ma;
  logic [MAN_W-1:0]       mb;

  logic                   out_valid;
  logic                   out_ready;
  logic                   a_gr_b;
  logic [EXP_W-1:0]       e_big;
  logic [EXP_W-1:0]       diff;
  logic [MAN_W+GRD_W-1:0] m_big;
  logic [MAN_W+GRD_W-1:0] m_small;

  modport master (
    output in_valid, ea, eb, ma, mb, out_ready,
    input  in_ready, out_valid, a_gr_b, e_big, diff, m_big, m_small
  );

  modport slave (
    input  in_valid, ea, eb, ma, mb, out_ready,
    output in_ready, out_valid, a_gr_b, e_big, diff, m_big, m_small
  );

endinterface

// File: rtl/fp_exp_align_shifter.sv
// Combinational log2 barrel right shifter with saturating shift amount and
// a sticky flag that ORs every bit pushed out past the LSB.
module fp_exp_align_shifter #(
  parameter int EXP_W = 8,
  parameter int W     = 27
) (
  input  logic [W-1:0]     din_i,
  input  logic [EXP_W-1:0] amt_i,
  output logic [W-1:0]     dout_o,
  output logic             sticky_o
);

  // Enough stages to cover any in-range amount 0..W-1.
  localparam int SH_W = $clog2(W);

  logic [SH_W:0][W-1:0] stage;
  logic [SH_W:0]        stk;
  logic                 sat;

  assign stage[0] = din_i;
  assign stk[0]   = 1'b0;

  // Stage gi shifts by 2**gi and collects the bits it drops into the sticky chain.
  generate
    for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
      assign stage[gi+1] = amt_i[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
      assign stk[gi+1]   = stk[gi] | (amt_i[gi] & (|stage[gi][(1<<gi)-1:0]));
    end
  endgenerate

  // Any amount at or beyond the full width flushes the whole value.
  assign sat      = ({{(32-EXP_W){1'b0}}, amt_i} >= 32'(W));
  assign dout_o   = sat ? '0 : stage[SH_W];
  assign sticky_o = sat ? (|din_i) : stk[SH_W];

endmodule

// File: rtl/fp_exp_align.sv
// Two-stage pipelined exponent compare + mantissa align for the FPU adder.
// S1 registers the compare/swap, S2 registers the shifted small mantissa.
// Optional build macro: FP_ALIGN_STICKY_EN folds the shifted-out bits into m_small[0].
module fp_exp_align
  import fp_exp_align_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int GRD_W = GRD_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_exp_align_if.slave bus
);

  localparam int W = align_w(MAN_W, GRD_W);

  // Handshake
  logic s1_ready;
  logic s2_ready;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_a_gr_b_q, s1_a_gr_b_d;
  logic [EXP_W-1:0] s1_e_big_q, s1_e_big_d;
  logic [EXP_W-1:0] s1_diff_q, s1_diff_d;
  logic [MAN_W-1:0] s1_m_big_q, s1_m_big_d;
  logic [MAN_W-1:0] s1_m_small_q, s1_m_small_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic             s2_a_gr_b_q, s2_a_gr_b_d;
  logic [EXP_W-1:0] s2_e_big_q, s2_e_big_d;
  logic [EXP_W-1:0] s2_diff_q, s2_diff_d;
  logic [W-1:0]     s2_m_big_q, s2_m_big_d;
  logic [W-1:0]     s2_m_small_q, s2_m_small_d;

  // Compare: one extra bit on the subtract so the borrow tells us which is larger.
  logic [EXP_W:0]   sub_ab;
  logic             a_ge_b;
  logic [EXP_W-1:0] sub_ba;

  assign sub_ab = {1'b0, bus.ea} - {1'b0, bus.eb};
  assign a_ge_b = ~sub_ab[EXP_W];
  assign sub_ba = bus.eb - bus.ea;

  // S2 can take new data when empty or when its current result leaves this cycle.
  assign s2_ready     = ~s2_valid_q | bus.out_ready;
  assign s1_ready     = ~s1_valid_q | s2_ready;
  assign bus.in_ready = s1_ready;

  // Stage 1 next state: compare exponents and swap operands so "big" has the larger exponent.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_gr_b_d  = s1_a_gr_b_q;
    s1_e_big_d   = s1_e_big_q;
    s1_diff_d    = s1_diff_q;
    s1_m_big_d   = s1_m_big_q;
    s1_m_small_d = s1_m_small_q;
    if (s1_ready) begin
      s1_valid_d = bus.in_valid;
    end
    if (s1_ready && bus.in_valid) begin
      s1_a_gr_b_d  = a_ge_b;
      s1_e_big_d   = a_ge_b ? bus.ea : bus.eb;
      s1_diff_d    = a_ge_b ? sub_ab[EXP_W-1:0] : sub_ba;
      s1_m_big_d   = a_ge_b ? bus.ma : bus.mb;
      s1_m_small_d = a_ge_b ? bus.mb : bus.ma;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_gr_b_q  <= 1'b0;
      s1_e_big_q   <= '0;
      s1_diff_q    <= '0;
      s1_m_big_q   <= '0;
      s1_m_small_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_gr_b_q  <= s1_a_gr_b_d;
      s1_e_big_q   <= s1_e_big_d;
      s1_diff_q    <= s1_diff_d;
      s1_m_big_q   <= s1_m_big_d;
      s1_m_small_q <= s1_m_small_d;
    end
  end

  // Alignment shift of the small mantissa (guard bits appended as zeros).
  logic [W-1:0] sh_out;
  logic         sh_sticky;
  logic [W-1:0] m_small_w;

  fp_exp_align_shifter #(
    .EXP_W (EXP_W),
    .W     (W)
  ) u_shifter (
    .din_i    ({s1_m_small_q, {GRD_W{1'b0}}}),
    .amt_i    (s1_diff_q),
    .dout_o   (sh_out),
    .sticky_o (sh_sticky)
  );

`ifdef FP_ALIGN_STICKY_EN
  assign m_small_w = {sh_out[W-1:1], sh_out[0] | sh_sticky};
`else
  // Truncating build: shifted-out bits are simply dropped.
  logic unused_sticky;
  assign unused_sticky = sh_sticky;
  assign m_small_w     = sh_out;
`endif

  // Stage 2 next state: capture the aligned pair when S1 hands over.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_a_gr_b_d  = s2_a_gr_b_q;
    s2_e_big_d   = s2_e_big_q;
    s2_diff_d    = s2_diff_q;
    s2_m_big_d   = s2_m_big_q;
    s2_m_small_d = s2_m_small_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_ready && s1_valid_q) begin
      s2_a_gr_b_d  = s1_a_gr_b_q;
      s2_e_big_d   = s1_e_big_q;
      s2_diff_d    = s1_diff_q;
      s2_m_big_d   = {s1_m_big_q, {GRD_W{1'b0}}};
      s2_m_small_d = m_small_w;
    end
  end

  // Stage 2 registers (drive the outputs directly, so they hold while stalled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_a_gr_b_q  <= 1'b0;
      s2_e_big_q   <= '0;
      s2_diff_q    <= '0;
      s2_m_big_q   <= '0;
      s2_m_small_q <= '0;
    end else begin
      s2_valid_q   <= s2_valid_d;
      s2_a_gr_b_q  <= s2_a_gr_b_d;
      s2_e_big_q   <= s2_e_big_d;
      s2_diff_q    <= s2_diff_d;
      s2_m_big_q   <= s2_m_big_d;
      s2_m_small_q <= s2_m_small_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.a_gr_b    = s2_a_gr_b_q;
  assign bus.e_big     = s2_e_big_q;
  assign bus.diff      = s2_diff_q;
  assign bus.m_big     = s2_m_big_q;
  assign bus.m_small   = s2_m_small_q;

endmodule

// File: tb/tb_fp_exp_align.sv
// Directed bench for fp_exp_align: single ops, saturation/sticky boundaries,
// a stalled 8-op stream and an asynchronous reset with data in flight.
module tb_fp_exp_align;
  import fp_exp_align_pkg::*;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fp_exp_align_if #(.EXP_W(8), .MAN_W(24), .GRD_W(3)) bus ();

  fp_exp_align #(.EXP_W(8), .MAN_W(24), .GRD_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // One op through an empty pipe: checks acceptance, 2-cycle latency and every field.
  task automatic run_single(input string tag,
                            input logic [7:0] ea, input logic [7:0] eb,
                            input logic [23:0] ma, input logic [23:0] mb,
                            input logic x_agb, input logic [7:0] x_ebig, input logic [7:0] x_diff,
                            input logic [26:0] x_mbig, input logic [26:0] x_msmall);
    @(negedge clk);
    bus.ea = ea; bus.eb = eb; bus.ma = ma; bus.mb = mb;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check({tag, "_lat1_valid"}, bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_lat2_valid"}, bus.out_valid, 1'b1);
    check({tag, "_a_gr_b"},  bus.a_gr_b,  x_agb);
    check({tag, "_e_big"},   bus.e_big,   x_ebig);
    check({tag, "_diff"},    bus.diff,    x_diff);
    check({tag, "_m_big"},   bus.m_big,   x_mbig);
    check({tag, "_m_small"}, bus.m_small, x_msmall);
  endtask

  logic [26:0] str_small [8];
  logic [26:0] held_small;
  logic [7:0]  held_ebig;
  logic [7:0]  held_diff;
  logic        stall_prev;
  int          wr, rd, cyc, occ;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ea = '0; bus.eb = '0; bus.ma = '0; bus.mb = '0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_m_small",   bus.m_small,   27'h0);
    check("rst_e_big",     bus.e_big,     8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic compare/align, equal exponents, B larger with saturation.
    run_single("t1", 8'h85, 8'h82, 24'h800000, 24'h800000,
               1'b1, 8'h85, 8'h03, 27'h4000000, 27'h0800000);
    run_single("t2", 8'h7F, 8'h7F, 24'h123456, 24'h654321,
               1'b1, 8'h7F, 8'h00, 27'h091A2B0, 27'h32A1908);
    run_single("t3", 8'h10, 8'hF0, 24'hFFFFFF, 24'h800000,
               1'b0, 8'hF0, 8'hE0, 27'h4000000, STK ? 27'h1 : 27'h0);
    // One set bit falls off below the guard bits.
    run_single("t4", 8'h84, 8'h80, 24'h800000, 24'h800001,
               1'b1, 8'h84, 8'h04, 27'h4000000, STK ? 27'h0400001 : 27'h0400000);
    // Largest in-range shift and first saturating shift.
    run_single("t_d26", 8'h9A, 8'h80, 24'h800000, 24'hFFFFFF,
               1'b1, 8'h9A, 8'h1A, 27'h4000000, 27'h0000001);
    run_single("t_d27", 8'h9B, 8'h80, 24'h800000, 24'hFFFFFF,
               1'b1, 8'h9B, 8'h1B, 27'h4000000, STK ? 27'h1 : 27'h0);

    // Stream: op i has ea=80+i, eb=80, mb=C00000 -> m_small = 27'h6000000 >> i.
    str_small[0] = 27'h6000000; str_small[1] = 27'h3000000;
    str_small[2] = 27'h1800000; str_small[3] = 27'h0C00000;
    str_small[4] = 27'h0600000; str_small[5] = 27'h0300000;
    str_small[6] = 27'h0180000; str_small[7] = 27'h00C0000;
    @(negedge clk);
    wr = 0; rd = 0; cyc = 0; stall_prev = 1'b0;
    held_small = '0; held_ebig = '0; held_diff = '0;
    while (rd < 8 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (wr < 8) begin
        bus.ea = 8'h80 + 8'(wr); bus.eb = 8'h80;
        bus.ma = 24'h800000 | 24'(wr); bus.mb = 24'hC00000;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check("stall_valid",   bus.out_valid, 1'b1);
        check("stall_m_small", bus.m_small,   held_small);
        check("stall_e_big",   bus.e_big,     held_ebig);
        check("stall_diff",    bus.diff,      held_diff);
      end
      occ = wr - rd;
      check("str_in_ready", bus.in_ready, !(occ == 2 && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("str%0d_e_big", rd),   bus.e_big,   8'h80 + 8'(rd));
        check($sformatf("str%0d_diff", rd),    bus.diff,    8'(rd));
        check($sformatf("str%0d_m_big", rd),   bus.m_big,   {24'h800000 | 24'(rd), 3'b000});
        check($sformatf("str%0d_m_small", rd), bus.m_small, str_small[rd]);
        rd++;
      end
      if (bus.in_valid && bus.in_ready) wr++;
      stall_prev = bus.out_valid && !bus.out_ready;
      held_small = bus.m_small;
      held_ebig  = bus.e_big;
      held_diff  = bus.diff;
      cyc++;
    end
    check("str_count", 32'(rd), 32'd8);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("str_drained", bus.out_valid, 1'b0);

    // Reset with two ops in flight.
    @(negedge clk);
    bus.ea = 8'h85; bus.eb = 8'h82; bus.ma = 24'h800000; bus.mb = 24'h800000;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.ea = 8'h90;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("pre_rst_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   bus.out_valid, 1'b0);
    check("mid_rst_m_small", bus.m_small,   27'h0);
    check("mid_rst_e_big",   bus.e_big,     8'h00);
    check("mid_rst_in_rdy",  bus.in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_idle", bus.out_valid, 1'b0);
    run_single("post_rst", 8'h85, 8'h82, 24'h800000, 24'h800000,
               1'b1, 8'h85, 8'h03, 27'h4000000, 27'h0800000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
